// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M/RV64M mult/div unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_SETUP,
        DIV_ITER,
        DIV_FIX
    } md_state_e;

    function automatic logic is_div(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_result_fifo.sv
// Result queue between the iterative unit and the CDB; the caller guarantees space on push.
module muldiv_result_fifo #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 6,
    parameter int RESULT_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 flush,
    input  logic                                 push,
    input  logic [XLEN-1:0]                      push_result,
    input  logic [TAG_W-1:0]                     push_tag,
    input  logic                                 pop,
    output logic [$clog2(RESULT_DEPTH+1)-1:0]    count,
    output logic                                 head_valid,
    output logic [XLEN-1:0]                      head_result,
    output logic [TAG_W-1:0]                     head_tag
);
    localparam int PW = $clog2(RESULT_DEPTH);
    localparam int CW = $clog2(RESULT_DEPTH + 1);

    logic [RESULT_DEPTH-1:0][XLEN-1:0]  res_mem_q;
    logic [RESULT_DEPTH-1:0][TAG_W-1:0] tag_mem_q;
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign head_valid  = cnt_q != '0;
    assign do_pop      = pop & head_valid;
    assign count       = cnt_q;
    // Empty queue drives zeros so the bus never shows a stale entry.
    assign head_result = head_valid ? res_mem_q[rd_q] : '0;
    assign head_tag    = head_valid ? tag_mem_q[rd_q] : '0;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !do_pop)
            cnt_d = cnt_q + CW'(1);
        else if (!push && do_pop)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)   wr_q <= wr_q + PW'(1);
            if (do_pop) rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            res_mem_q[wr_q] <= push_result;
            tag_mem_q[wr_q] <= push_tag;
        end
    end

endmodule

// File: rtl/mult_div_iter_unit.sv
// Iterative RV32M/RV64M mult/div unit (fixed-latency MUL, radix-2 restoring DIV) feeding a CDB queue.
// Define DIV_EARLY_EXIT_EN to resolve divides with |src1| < |src2| right after setup.
module mult_div_iter_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 6,
    parameter int MUL_LAT      = 3,
    parameter int RESULT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_grant,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int QC_W  = $clog2(RESULT_DEPTH + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  src1_q, src2_q;
    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic [QC_W-1:0]  q_count;
    logic             accept, push;
    logic [XLEN-1:0]  push_result, mul_result, div_result, quo_fix, rem_fix;

    assign in_ready = reset_n & (state_q == IDLE) & (q_count < QC_W'(RESULT_DEPTH)) & ~flush;
    assign accept   = in_valid & in_ready;

    // Operand decode shared by the multiplier and divide setup.
    logic            s1, s2, div_zero, div_ovf, early;
    logic [XLEN-1:0] mag1, mag2;
    assign s1       = is_signed_a(op_q) & src1_q[XLEN-1];
    assign s2       = is_signed_b(op_q) & src2_q[XLEN-1];
    assign mag1     = s1 ? -src1_q : src1_q;
    assign mag2     = s2 ? -src2_q : src2_q;
    assign div_zero = src2_q == '0;
    assign div_ovf  = is_signed_b(op_q) && (src1_q == INT_MIN) && (src2_q == '1);
`ifdef DIV_EARLY_EXIT_EN
    assign early    = mag1 < mag2;
`else
    assign early    = 1'b0;
`endif

    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    assign a_ext      = {{XLEN{s1}}, src1_q};
    assign b_ext      = {{XLEN{s2}}, src2_q};
    assign prod       = a_ext * b_ext;
    assign mul_result = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff;
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[XLEN-1:0] - dvs_q;

    assign quo_fix    = negq_q ? -quo_q : quo_q;
    assign rem_fix    = negr_q ? -rem_q : rem_q;
    assign div_result = (op_q inside {MD_REM, MD_REMU}) ? rem_fix : quo_fix;

    assign push        = ((state_q == MUL) && (cnt_q == '0)) || (state_q == DIV_FIX);
    assign push_result = (state_q == MUL) ? mul_result : div_result;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = is_div(md_op_e'(in_op)) ? DIV_SETUP : MUL;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end
            end
            MUL: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DIV_SETUP: begin
                state_d = DIV_ITER;
                cnt_d   = CNT_W'(XLEN);
                quo_d   = mag1;
                rem_d   = '0;
                dvs_d   = mag2;
                negq_d  = s1 ^ s2;
                negr_d  = s1;
                // Special cases load final values and skip straight to the write-back.
                if (div_zero || div_ovf || early) begin
                    state_d = DIV_FIX;
                    negq_d  = 1'b0;
                    negr_d  = 1'b0;
                    if (div_zero) begin
                        quo_d = '1;
                        rem_d = src1_q;
                    end else if (div_ovf) begin
                        quo_d = src1_q;
                        rem_d = '0;
                    end else begin
                        quo_d = '0;
                        rem_d = src1_q;
                    end
                end
            end
            DIV_ITER: begin
                quo_d = {quo_q[XLEN-2:0], ge};
                rem_d = ge ? diff : shifted[XLEN-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DIV_FIX;
            end
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= MD_MUL;
            tag_q  <= '0;
            src1_q <= '0;
            src2_q <= '0;
        end else if (accept) begin
            op_q   <= md_op_e'(in_op);
            tag_q  <= in_tag;
            src1_q <= in_src1;
            src2_q <= in_src2;
        end
    end

    muldiv_result_fifo #(
        .XLEN         (XLEN),
        .TAG_W        (TAG_W),
        .RESULT_DEPTH (RESULT_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .push        (push),
        .push_result (push_result),
        .push_tag    (tag_q),
        .pop         (out_grant),
        .count       (q_count),
        .head_valid  (out_valid),
        .head_result (out_result),
        .head_tag    (out_tag)
    );

endmodule

// File: tb/tb_mult_div_iter_unit.sv
// Directed scoreboard bench for mult_div_iter_unit at default parameters (XLEN=32, MUL_LAT=3, DEPTH=4).
module tb_mult_div_iter_unit;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_grant = 1'b0;
    logic        in_ready, out_valid;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_src1 = '0, in_src2 = '0, out_result;
    logic [5:0]  in_tag = '0, out_tag;
    logic [5:0]  next_tag = '0;
    int          checks = 0, errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mult_div_iter_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_grant  (out_grant),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb_, za, zb, p;
        int ia, ib;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        za  = {32'd0, a};
        zb  = {32'd0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        case (op)
            MD_MUL:    begin p = za * zb;  return p[31:0];  end
            MD_MULH:   begin p = sa * sb_; return p[63:32]; end
            MD_MULHSU: begin p = sa * zb;  return p[63:32]; end
            MD_MULHU:  begin p = za * zb;  return p[63:32]; end
            MD_DIV:    if (b == 0) return 32'hFFFFFFFF;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                       else return 32'(ia / ib);
            MD_REM:    if (b == 0) return a;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                       else return 32'(ia % ib);
            MD_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv);
        int n = 0;
        while (!in_ready && n < 200) begin tick(); n++; end
        check("issue_ready", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = next_tag;
        tick();
        in_valid = 1'b0;
        sb.push_back('{res: expv, tag: next_tag});
        next_tag++;
    endtask

    task automatic expect_latency(input string name, input int lat_exp);
        int lat = 0;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        check(name, lat, lat_exp);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            if (out_valid) begin
                check({name, "_res"}, out_result, sb[0].res);
                check({name, "_tag"}, out_tag, sb[0].tag);
                void'(sb.pop_front());
                out_grant = 1'b1;
                tick();
                out_grant = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_empty"}, out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        md_op_e      op;
        logic [31:0] a, b;
        int          stale;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        reset_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);

        issue(MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        expect_latency("mul_lat", MUL_LAT);
        drain("mul");
        issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        drain("mulhu");
        issue(MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        drain("mulh");
        issue(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        drain("mulhsu");

        issue(MD_REMU, 32'd100, 32'd7, 32'd2);
        expect_latency("remu_lat", 34);
        drain("remu");
        issue(MD_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2);
        expect_latency("div_lat", 34);
        drain("div");

        issue(MD_DIV, 32'd5, 32'd0, 32'hFFFFFFFF);
        expect_latency("div0_lat", 2);
        drain("div0");
        issue(MD_REM, 32'd5, 32'd0, 32'd5);
        expect_latency("rem0_lat", 2);
        drain("rem0");
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        expect_latency("divovf_lat", 2);
        drain("divovf");
        issue(MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        expect_latency("removf_lat", 2);
        drain("removf");

        issue(MD_DIVU, 32'd3, 32'd10, 32'd0);
`ifdef DIV_EARLY_EXIT_EN
        expect_latency("early_lat", 2);
`else
        expect_latency("early_lat", 34);
`endif
        drain("early");

        // A grant on an empty queue must not disturb the count.
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        check("grant_empty_valid", out_valid, 0);

        for (int i = 0; i < 4; i++)
            issue(MD_MUL, 32'(i + 2), 32'(1000 + i), 32'((i + 2) * (1000 + i)));
        repeat (MUL_LAT + 3) tick();
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_res", out_result, sb[0].res);
        check("bp_head_tag", out_tag, sb[0].tag);
        void'(sb.pop_front());
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        check("bp_in_ready_back", in_ready, 1);
        drain("bp");

        issue(MD_MUL, 32'd11, 32'd13, 32'd143);
        issue(MD_MULHU, 32'h12345678, 32'h9ABCDEF0, model(MD_MULHU, 32'h12345678, 32'h9ABCDEF0));
        issue(MD_DIVU, 32'd1000, 32'd3, 32'd333);
        repeat (11) tick();
        check("pre_flush_valid", out_valid, 1);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("post_flush_valid", out_valid, 0);
        check("post_flush_ready", in_ready, 1);
        sb.delete();
        stale = 0;
        repeat (40) begin
            tick();
            if (out_valid) stale++;
        end
        check("no_stale_result", stale, 0);
        issue(MD_MUL, 32'd6, 32'd7, 32'd42);
        drain("post_flush");

        issue(MD_MUL, 32'd3, 32'd5, 32'd15);
        issue(MD_DIV, 32'd1000, 32'd7, 32'd142);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 0);
        tick();
        reset_n = 1'b1;
        tick();
        sb.delete();
        check("postrst_valid", out_valid, 0);
        check("postrst_ready", in_ready, 1);

        for (int k = 0; k < 24; k++) begin
            op = md_op_e'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, model(op, a, b));
            if (k % 3 == 2) drain("rnd");
        end
        drain("rnd_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
